// File: rtl/regfile_write_arbiter_if.sv
// Handshake and write-port bundle between the writeback requesters, the arbiter and the register file.
interface regfile_write_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              alu_valid_i;
   logic              alu_ready_o;
   logic [ADDR_W-1:0] alu_add_i;
   logic [DATA_W-1:0] alu_dat_i;
   logic              mem_valid_i;
   logic              mem_ready_o;
   logic [ADDR_W-1:0] mem_add_i;
   logic [DATA_W-1:0] mem_dat_i;
   logic [ADDR_W-1:0] w_add_o;
   logic [DATA_W-1:0] w_dat_o;
   logic              write_en_o;
   logic              init_done_o;

   modport slave (
      input  alu_valid_i, alu_add_i, alu_dat_i,
      input  mem_valid_i, mem_add_i, mem_dat_i,
      output alu_ready_o, mem_ready_o,
      output w_add_o, w_dat_o, write_en_o, init_done_o
   );

   modport master (
      output alu_valid_i, alu_add_i, alu_dat_i,
      output mem_valid_i, mem_add_i, mem_dat_i,
      input  alu_ready_o, mem_ready_o,
      input  w_add_o, w_dat_o, write_en_o, init_done_o
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Single register-file write port: clears all writable registers after reset, then
// round-robins between ALU and load writebacks, each buffered in a one-entry slot.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_INIT | writing zero to registers 0..NUM_REGS-2, both ready low
//   ST_RUN  | accepting requests, arbitrating slots onto the write port
module regfile_write_arbiter #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   regfile_write_arbiter_if.slave  bus
);
   typedef enum logic {ST_INIT, ST_RUN} state_t;

   localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(NUM_REGS - 1);
   localparam logic [ADDR_W-1:0] LAST_CLR = ADDR_W'(NUM_REGS - 2);

   state_t            r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_last_mem;
   logic              r_alu_full;
   logic [ADDR_W-1:0] r_alu_add;
   logic [DATA_W-1:0] r_alu_dat;
   logic              r_mem_full;
   logic [ADDR_W-1:0] r_mem_add;
   logic [DATA_W-1:0] r_mem_dat;
   logic [ADDR_W-1:0] r_w_add;
   logic [DATA_W-1:0] r_w_dat;
   logic              r_we;

   logic w_run;
   logic w_gnt_alu;
   logic w_gnt_mem;
   logic w_alu_ready;
   logic w_mem_ready;
   logic w_alu_take;
   logic w_mem_take;

   assign w_run       = (r_state == ST_RUN);
   // On a tie the requester that did not win last time is granted.
   assign w_gnt_alu   = r_alu_full && (!r_mem_full || r_last_mem);
   assign w_gnt_mem   = r_mem_full && (!r_alu_full || !r_last_mem);
   assign w_alu_ready = w_run && (!r_alu_full || w_gnt_alu);
   assign w_mem_ready = w_run && (!r_mem_full || w_gnt_mem);
   assign w_alu_take  = bus.alu_valid_i && w_alu_ready;
   assign w_mem_take  = bus.mem_valid_i && w_mem_ready;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= ST_INIT;
         r_cnt      <= '0;
         r_last_mem <= 1'b1;
         r_alu_full <= 1'b0;
         r_alu_add  <= '0;
         r_alu_dat  <= '0;
         r_mem_full <= 1'b0;
         r_mem_add  <= '0;
         r_mem_dat  <= '0;
         r_w_add    <= '0;
         r_w_dat    <= '0;
         r_we       <= 1'b0;
      end else if (r_state == ST_INIT) begin
         r_we    <= 1'b1;
         r_w_add <= r_cnt;
         r_w_dat <= '0;
         r_cnt   <= r_cnt + 1'b1;
         if (r_cnt == LAST_CLR) begin
            r_state <= ST_RUN;
         end
      end else begin
         // Writes to the hardwired-zero register are consumed but never reach the port.
         if (w_gnt_alu) begin
            r_we       <= (r_alu_add != ZERO_REG);
            r_last_mem <= 1'b0;
            if (r_alu_add != ZERO_REG) begin
               r_w_add <= r_alu_add;
               r_w_dat <= r_alu_dat;
            end
         end else if (w_gnt_mem) begin
            r_we       <= (r_mem_add != ZERO_REG);
            r_last_mem <= 1'b1;
            if (r_mem_add != ZERO_REG) begin
               r_w_add <= r_mem_add;
               r_w_dat <= r_mem_dat;
            end
         end else begin
            r_we <= 1'b0;
         end

         if (w_alu_take) begin
            r_alu_full <= 1'b1;
            r_alu_add  <= bus.alu_add_i;
            r_alu_dat  <= bus.alu_dat_i;
         end else if (w_gnt_alu) begin
            r_alu_full <= 1'b0;
         end

         if (w_mem_take) begin
            r_mem_full <= 1'b1;
            r_mem_add  <= bus.mem_add_i;
            r_mem_dat  <= bus.mem_dat_i;
         end else if (w_gnt_mem) begin
            r_mem_full <= 1'b0;
         end
      end
   end

   assign bus.alu_ready_o = w_alu_ready;
   assign bus.mem_ready_o = w_mem_ready;
   assign bus.w_add_o     = r_w_add;
   assign bus.w_dat_o     = r_w_dat;
   assign bus.write_en_o  = r_we;
   assign bus.init_done_o = w_run;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: clear sequence, per-cycle vector table with a write-order scoreboard, reset mid-flight.
module tb_regfile_write_arbiter;
   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int NR    = 32;
   localparam int NROWS = 26;

   typedef struct {
      logic        av;
      logic [4:0]  aa;
      logic [31:0] ad;
      logic        mv;
      logic [4:0]  ma;
      logic [31:0] md;
      logic        ear;
      logic        emr;
      logic        ewe;
      logic [1:0]  np;
      logic [4:0]  p0a;
      logic [31:0] p0d;
      logic [4:0]  p1a;
      logic [31:0] p1d;
   } row_t;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   logic mon_en   = 1'b0;
   wr_t  exp_q[$];
   logic [31:0] rf_model [NR];
   row_t tbl [NROWS];

   always #5 clk = ~clk;

   regfile_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   regfile_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic row_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                               input logic mv, input logic [4:0] ma, input logic [31:0] md,
                               input logic ear, input logic emr, input logic ewe,
                               input logic [1:0] np, input logic [4:0] p0a, input logic [31:0] p0d,
                               input logic [4:0] p1a, input logic [31:0] p1d);
      row_t r;
      r.av = av;   r.aa = aa;   r.ad = ad;
      r.mv = mv;   r.ma = ma;   r.md = md;
      r.ear = ear; r.emr = emr; r.ewe = ewe;
      r.np = np;   r.p0a = p0a; r.p0d = p0d; r.p1a = p1a; r.p1d = p1d;
      return r;
   endfunction

   function automatic row_t idle(input logic ear, input logic emr, input logic ewe);
      return mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, ear, emr, ewe, 2'd0, 5'd0, 32'h0, 5'd0, 32'h0);
   endfunction

   // Downstream register file fed by the DUT write port; each write must match the next expected one.
   always @(negedge clk) begin
      if (mon_en && bus.write_en_o) begin
         rf_model[bus.w_add_o] = bus.w_dat_o;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL wr_unexpected actual_add=%0h actual_dat=%0h required=no_write", bus.w_add_o, bus.w_dat_o);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_add", 32'(bus.w_add_o), 32'(e.a));
            chk("wr_dat", bus.w_dat_o, e.d);
         end
      end
   end

   task automatic check_init();
      for (int k = 1; k <= NR - 1; k++) begin
         @(negedge clk);
         chk($sformatf("clr%0d_we", k), 32'(bus.write_en_o), 32'd1);
         chk($sformatf("clr%0d_add", k), 32'(bus.w_add_o), 32'(k - 1));
         chk($sformatf("clr%0d_dat", k), bus.w_dat_o, 32'h0);
         chk($sformatf("clr%0d_done", k), 32'(bus.init_done_o), (k == NR - 1) ? 32'd1 : 32'd0);
         if (k < NR - 1) begin
            chk($sformatf("clr%0d_alu_rdy", k), 32'(bus.alu_ready_o), 32'd0);
            chk($sformatf("clr%0d_mem_rdy", k), 32'(bus.mem_ready_o), 32'd0);
         end
      end
      @(negedge clk);
      chk("clr_end_we", 32'(bus.write_en_o), 32'd0);
      chk("clr_end_done", 32'(bus.init_done_o), 32'd1);
      chk("clr_end_alu_rdy", 32'(bus.alu_ready_o), 32'd1);
      chk("clr_end_mem_rdy", 32'(bus.mem_ready_o), 32'd1);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_we"}, 32'(bus.write_en_o), 32'd0);
      chk({tag, "_add"}, 32'(bus.w_add_o), 32'd0);
      chk({tag, "_dat"}, bus.w_dat_o, 32'h0);
      chk({tag, "_done"}, 32'(bus.init_done_o), 32'd0);
      chk({tag, "_alu_rdy"}, 32'(bus.alu_ready_o), 32'd0);
      chk({tag, "_mem_rdy"}, 32'(bus.mem_ready_o), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // ALU alone, back-to-back
      tbl[0]  = mk(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 2'd1, 5'd1, 32'h11, 5'd0, 32'h0);
      tbl[1]  = mk(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 2'd1, 5'd2, 32'h22, 5'd0, 32'h0);
      tbl[2]  = mk(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1, 2'd1, 5'd3, 32'h33, 5'd0, 32'h0);
      tbl[3]  = idle(1'b1, 1'b1, 1'b1);
      tbl[4]  = idle(1'b1, 1'b1, 1'b1);
      tbl[5]  = idle(1'b1, 1'b1, 1'b0);
      // MEM write to the zero register is dropped, then a normal one
      tbl[6]  = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 2'd0, 5'd0, 32'h0, 5'd0, 32'h0);
      tbl[7]  = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66, 1'b1, 1'b1, 1'b0, 2'd1, 5'd6, 32'h66, 5'd0, 32'h0);
      tbl[8]  = idle(1'b1, 1'b1, 1'b0);
      tbl[9]  = idle(1'b1, 1'b1, 1'b1);
      tbl[10] = idle(1'b1, 1'b1, 1'b0);
      // Both requesters continuously valid: ALU, MEM, ALU, MEM ...
      tbl[11] = mk(1'b1, 5'd4, 32'hA0000001, 1'b1, 5'd5, 32'hB0000001, 1'b1, 1'b1, 1'b0, 2'd2, 5'd4, 32'hA0000001, 5'd5, 32'hB0000001);
      tbl[12] = mk(1'b1, 5'd4, 32'hA0000002, 1'b1, 5'd5, 32'hB0000002, 1'b1, 1'b0, 1'b0, 2'd1, 5'd4, 32'hA0000002, 5'd0, 32'h0);
      tbl[13] = mk(1'b1, 5'd4, 32'hA0000003, 1'b1, 5'd5, 32'hB0000002, 1'b0, 1'b1, 1'b1, 2'd1, 5'd5, 32'hB0000002, 5'd0, 32'h0);
      tbl[14] = mk(1'b1, 5'd4, 32'hA0000003, 1'b1, 5'd5, 32'hB0000003, 1'b1, 1'b0, 1'b1, 2'd1, 5'd4, 32'hA0000003, 5'd0, 32'h0);
      tbl[15] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hB0000003, 1'b0, 1'b1, 1'b1, 2'd1, 5'd5, 32'hB0000003, 5'd0, 32'h0);
      tbl[16] = idle(1'b1, 1'b0, 1'b1);
      tbl[17] = idle(1'b1, 1'b1, 1'b1);
      tbl[18] = idle(1'b1, 1'b1, 1'b1);
      tbl[19] = idle(1'b1, 1'b1, 1'b0);
      // Last grant ALU, then both to register 7: MEM commits first, ALU value survives
      tbl[20] = mk(1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 2'd1, 5'd8, 32'h88, 5'd0, 32'h0);
      tbl[21] = mk(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 1'b1, 1'b1, 1'b0, 2'd2, 5'd7, 32'h2, 5'd7, 32'h1);
      tbl[22] = idle(1'b0, 1'b1, 1'b1);
      tbl[23] = idle(1'b1, 1'b1, 1'b1);
      tbl[24] = idle(1'b1, 1'b1, 1'b1);
      tbl[25] = idle(1'b1, 1'b1, 1'b0);

      for (int i = 0; i < NR; i++) rf_model[i] = 32'hFFFF_FFFF;

      bus.alu_valid_i = 1'b0;
      bus.alu_add_i   = '0;
      bus.alu_dat_i   = '0;
      bus.mem_valid_i = 1'b0;
      bus.mem_add_i   = '0;
      bus.mem_dat_i   = '0;

      #2 rst_n = 1'b0;
      #1 check_all_zero("rst");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_init();

      mon_en = 1'b1;
      for (int i = 0; i < NROWS; i++) begin
         @(negedge clk);
         chk($sformatf("row%0d_we", i), 32'(bus.write_en_o), 32'(tbl[i].ewe));
         bus.alu_valid_i = tbl[i].av;
         bus.alu_add_i   = tbl[i].aa;
         bus.alu_dat_i   = tbl[i].ad;
         bus.mem_valid_i = tbl[i].mv;
         bus.mem_add_i   = tbl[i].ma;
         bus.mem_dat_i   = tbl[i].md;
         #1;
         chk($sformatf("row%0d_alu_rdy", i), 32'(bus.alu_ready_o), 32'(tbl[i].ear));
         chk($sformatf("row%0d_mem_rdy", i), 32'(bus.mem_ready_o), 32'(tbl[i].emr));
         if (tbl[i].np >= 2'd1) exp_q.push_back('{tbl[i].p0a, tbl[i].p0d});
         if (tbl[i].np == 2'd2) exp_q.push_back('{tbl[i].p1a, tbl[i].p1d});
      end
      @(negedge clk);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      chk("reg7_final", rf_model[7], 32'h1);
      chk("reg31_untouched", rf_model[31], 32'hFFFF_FFFF);

      // Fill both slots, then reset before either drains
      mon_en = 1'b0;
      bus.alu_valid_i = 1'b1;
      bus.alu_add_i   = 5'd4;
      bus.alu_dat_i   = 32'hAAAA_AAAA;
      bus.mem_valid_i = 1'b1;
      bus.mem_add_i   = 5'd5;
      bus.mem_dat_i   = 32'hBBBB_BBBB;
      @(posedge clk);
      #1;
      bus.alu_valid_i = 1'b0;
      bus.mem_valid_i = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_all_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      check_init();
      mon_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("post_rst%0d_we", i), 32'(bus.write_en_o), 32'd0);
      end
      mon_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
